// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected neuron blocks.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    // Full-precision accumulator width: product bits plus growth for LAYER_SZ terms plus headroom for bias.
    function automatic int acc_width(input int size, input int layer_sz);
        return 2 * size + $clog2(layer_sz) + 1;
    endfunction

    function automatic int q_one(input int precision);
        return 1 << precision;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantiser: adds bias, drops fraction bits (floor), optional ReLU, saturates to SIZE bits.
module fc_requant
    import fc_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int PRECISION = 11,
    parameter int ACC_W     = 35
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SIZE-1:0]  bias,
    input  logic             relu_en,
    output logic [SIZE-1:0]  value,
    output logic             ovf
);

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rect;
    logic [ACC_W-SIZE:0]     hi;

    assign bias_ext = ACC_W'($signed(bias));
    assign sum      = $signed(acc) + (bias_ext <<< PRECISION);
    assign shifted  = sum >>> PRECISION;

    always_comb begin
        rect  = shifted;
        value = '0;
        ovf   = 1'b0;
        if (relu_en && shifted[ACC_W-1]) begin
            rect = '0;
        end
        // In range only if every bit above the result sign bit matches it.
        hi = rect[ACC_W-1:SIZE-1];
        if (hi != '0 && hi != '1) begin
            ovf   = 1'b1;
            value = rect[ACC_W-1] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
        end else begin
            value = rect[SIZE-1:0];
        end
    end

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: LANES MACs per cycle, then requantise and pulse done.
module fc_neuron_seq
    import fc_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int PRECISION = 11,
    parameter int LAYER_SZ  = 4,
    parameter int LANES     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [0:LAYER_SZ-1][SIZE-1:0]  weights,
    input  logic [0:LAYER_SZ-1][SIZE-1:0]  inputs,
    input  logic [SIZE-1:0]                bias,
    input  logic                           relu_en,
    output logic                           busy,
    output logic                           done,
    output logic [SIZE-1:0]                value,
    output logic                           ovf
);

    localparam int ACC_W = acc_width(SIZE, LAYER_SZ);
    localparam int IDX_W = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_SZ - LANES);

    if (LAYER_SZ < 1 || LANES < 1 || (LAYER_SZ % LANES) != 0) begin : g_bad_cfg
        $error("fc_neuron_seq: LANES must divide LAYER_SZ and both must be >= 1");
    end

    state_e                          state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [0:LAYER_SZ-1][SIZE-1:0]   w_q, x_q;
    logic [SIZE-1:0]                 bias_q;
    logic                            relu_q;
    logic [SIZE-1:0]                 value_q, value_d;
    logic                            ovf_q, ovf_d;
    logic                            done_q, done_d;
    logic                            load;

    logic signed [ACC_W-1:0]         chunk;
    logic signed [2*SIZE-1:0]        prod;
    logic [IDX_W-1:0]                k;
    logic [SIZE-1:0]                 rq_value;
    logic                            rq_ovf;

    always_comb begin
        chunk = '0;
        prod  = '0;
        k     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            k     = idx_q + IDX_W'(l);
            prod  = $signed(w_q[k]) * $signed(x_q[k]);
            chunk = chunk + ACC_W'(prod);
        end
    end

    fc_requant #(
        .SIZE      (SIZE),
        .PRECISION (PRECISION),
        .ACC_W     (ACC_W)
    ) u_requant (
        .acc     (acc_q),
        .bias    (bias_q),
        .relu_en (relu_q),
        .value   (rq_value),
        .ovf     (rq_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + chunk;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(LANES);
                end
            end
            OUT: begin
                value_d = rq_value;
                ovf_d   = rq_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            w_q     <= '0;
            x_q     <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            value_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            if (load) begin
                w_q    <= weights;
                x_q    <= inputs;
                bias_q <= bias;
                relu_q <= relu_en;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign value = value_q;
    assign ovf   = ovf_q;

endmodule
